// File: rtl/soc_top.sv
// Debug-controlled SoC top: a UART command engine drives a 32-bit output
// register, samples a 32-bit input and streams SPI flash reads back to the host.
module soc_top #(
  parameter int BAUD_DIV = 868,
  parameter int SPI_DIV  = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] parallel_i,
  output logic [31:0] parallel_o,
  output logic        flashClk_o,
  output logic        flashMosi_o,
  input  logic        flashMiso_i,
  output logic        flashWp_o,
  output logic        flashHold_o,
  output logic        uartTx_o,
  input  logic        uartRx_i
);

  localparam logic [15:0] BAUD_M1      = 16'(BAUD_DIV - 1);
  localparam logic [15:0] BAUD_HALF_M1 = 16'(BAUD_DIV / 2 - 1);
  localparam logic [15:0] SPI_M1       = 16'(SPI_DIV - 1);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] ARGS       = 3'd1;
  localparam logic [2:0] REPLY      = 3'd2;
  localparam logic [2:0] FLASH_CMD  = 3'd3;
  localparam logic [2:0] FLASH_DATA = 3'd4;
  localparam logic [2:0] FLASH_WAIT = 3'd5;

  // ---------------------------------------------------------------- UART RX
  logic        rx_s1, rx_s2, rx_prev;
  logic        rx_busy;
  logic [15:0] rx_cnt;
  logic [3:0]  rx_bit;
  logic [7:0]  rx_sh;
  logic        rx_vld;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= uartRx_i;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // Receive framing: mid-bit sampling, glitch rejection on start, drop on bad stop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_busy <= 1'b0;
      rx_vld  <= 1'b0;
      rx_cnt  <= '0;
      rx_bit  <= '0;
    end else begin
      rx_vld <= 1'b0;
      if (!rx_busy) begin
        if (rx_prev && !rx_s2) begin
          rx_busy <= 1'b1;
          rx_cnt  <= BAUD_HALF_M1;
          rx_bit  <= 4'd0;
        end
      end else if (rx_cnt != 16'd0) begin
        rx_cnt <= rx_cnt - 16'd1;
      end else begin
        rx_cnt <= BAUD_M1;
        if (rx_bit == 4'd0) begin
          if (rx_s2) rx_busy <= 1'b0;
          else       rx_bit  <= 4'd1;
        end else if (rx_bit == 4'd9) begin
          rx_busy <= 1'b0;
          if (rx_s2) rx_vld <= 1'b1;
        end else begin
          rx_bit <= rx_bit + 4'd1;
        end
      end
    end
  end

  // Data bits arrive LSB first, so shift in from the top.
  always_ff @(posedge clk_i) begin
    if (rx_busy && rx_cnt == 16'd0 && rx_bit >= 4'd1 && rx_bit <= 4'd8)
      rx_sh <= {rx_s2, rx_sh[7:1]};
  end

  // ---------------------------------------------------------------- UART TX
  logic        tx_busy;
  logic [15:0] tx_cnt;
  logic [3:0]  tx_bit;
  logic [8:0]  tx_sh;
  logic        tx_line;
  logic        tx_end;
  logic        tx_ready;
  logic        tx_start;
  logic [7:0]  tx_data;

  // Ready in the final stop-bit cycle too, so reply bytes run back-to-back.
  assign tx_end   = tx_busy && (tx_cnt == 16'd0) && (tx_bit == 4'd9);
  assign tx_ready = !tx_busy || tx_end;

  // Transmit framing: start bit, 8 data bits LSB first, stop bit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_busy <= 1'b0;
      tx_line <= 1'b1;
      tx_cnt  <= '0;
      tx_bit  <= '0;
    end else if (tx_start) begin
      tx_busy <= 1'b1;
      tx_line <= 1'b0;
      tx_cnt  <= BAUD_M1;
      tx_bit  <= 4'd0;
    end else if (tx_busy) begin
      if (tx_cnt != 16'd0) begin
        tx_cnt <= tx_cnt - 16'd1;
      end else if (tx_bit == 4'd9) begin
        tx_busy <= 1'b0;
      end else begin
        tx_bit  <= tx_bit + 4'd1;
        tx_line <= tx_sh[0];
        tx_cnt  <= BAUD_M1;
      end
    end
  end

  // The stop bit rides in the top of the shifter behind the data bits.
  always_ff @(posedge clk_i) begin
    if (tx_start)
      tx_sh <= {1'b1, tx_data};
    else if (tx_busy && tx_cnt == 16'd0 && tx_bit != 4'd9)
      tx_sh <= {1'b1, tx_sh[8:1]};
  end

  // ---------------------------------------------------------------- Engine
  logic [2:0]  state;
  logic [7:0]  cmd;
  logic [2:0]  arg_cnt;
  logic [23:0] arg_sh;
  logic [31:0] rep_data;
  logic [2:0]  rep_cnt;
  logic        sck, mosi, hold;
  logic [15:0] spi_cnt;
  logic [5:0]  spi_bits;
  logic [30:0] spi_sh;
  logic [7:0]  miso_sh;
  logic [8:0]  len_cnt;

  assign tx_start = (((state == REPLY) && (rep_cnt != 3'd0)) || (state == FLASH_WAIT)) && tx_ready;
  assign tx_data  = (state == FLASH_WAIT) ? miso_sh : rep_data[31:24];

  // Command decode, argument collection, reply sequencing and SPI read control;
  // data-only registers are left out of reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      arg_cnt    <= '0;
      rep_cnt    <= '0;
      sck        <= 1'b0;
      mosi       <= 1'b0;
      hold       <= 1'b1;
      spi_cnt    <= '0;
      spi_bits   <= '0;
      len_cnt    <= '0;
      parallel_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_vld) begin
            cmd <= rx_sh;
            case (rx_sh)
              8'h57, 8'h46: begin
                arg_cnt <= 3'd4;
                state   <= ARGS;
              end
              8'h52: begin
                rep_data <= parallel_i;
                rep_cnt  <= 3'd4;
                state    <= REPLY;
              end
              8'h4F: begin
                rep_data <= parallel_o;
                rep_cnt  <= 3'd4;
                state    <= REPLY;
              end
              default: begin
                rep_data <= {8'h3F, 24'h0};
                rep_cnt  <= 3'd1;
                state    <= REPLY;
              end
            endcase
          end
        end
        ARGS: begin
          if (rx_vld) begin
            arg_sh  <= {arg_sh[15:0], rx_sh};
            arg_cnt <= arg_cnt - 3'd1;
            if (arg_cnt == 3'd1) begin
              if (cmd == 8'h57) begin
                parallel_o <= {arg_sh, rx_sh};
                rep_data   <= {8'h4B, 24'h0};
                rep_cnt    <= 3'd1;
                state      <= REPLY;
              end else begin
                // Read opcode 0x03 has MSB 0, so MOSI starts low; the rest queues here.
                spi_sh   <= {7'b0000011, arg_sh};
                mosi     <= 1'b0;
                len_cnt  <= (rx_sh == 8'h00) ? 9'd256 : {1'b0, rx_sh};
                hold     <= 1'b0;
                sck      <= 1'b0;
                spi_cnt  <= SPI_M1;
                spi_bits <= 6'd32;
                state    <= FLASH_CMD;
              end
            end
          end
        end
        REPLY: begin
          if (tx_start) begin
            rep_data <= {rep_data[23:0], 8'h00};
            rep_cnt  <= rep_cnt - 3'd1;
          end else if (rep_cnt == 3'd0 && !tx_busy) begin
            state <= IDLE;
          end
        end
        FLASH_CMD, FLASH_DATA: begin
          if (spi_cnt != 16'd0) begin
            spi_cnt <= spi_cnt - 16'd1;
          end else begin
            spi_cnt <= SPI_M1;
            if (!sck) begin
              sck <= 1'b1;
              if (state == FLASH_DATA) miso_sh <= {miso_sh[6:0], flashMiso_i};
            end else begin
              sck      <= 1'b0;
              spi_bits <= spi_bits - 6'd1;
              if (state == FLASH_CMD) begin
                spi_sh <= {spi_sh[29:0], 1'b0};
                if (spi_bits == 6'd1) begin
                  mosi     <= 1'b0;
                  spi_bits <= 6'd8;
                  state    <= FLASH_DATA;
                end else begin
                  mosi <= spi_sh[30];
                end
              end else if (spi_bits == 6'd1) begin
                state <= FLASH_WAIT;
              end
            end
          end
        end
        FLASH_WAIT: begin
          // SCK parks low here until the transmitter takes the byte.
          if (tx_start) begin
            if (len_cnt == 9'd1) begin
              hold    <= 1'b1;
              mosi    <= 1'b0;
              sck     <= 1'b0;
              len_cnt <= 9'd0;
              rep_cnt <= 3'd0;
              state   <= REPLY;
            end else begin
              len_cnt  <= len_cnt - 9'd1;
              spi_bits <= 6'd8;
              spi_cnt  <= SPI_M1;
              state    <= FLASH_DATA;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign flashClk_o  = sck;
  assign flashMosi_o = mosi;
  assign flashHold_o = hold;
  assign flashWp_o   = 1'b1;
  assign uartTx_o    = tx_line;

endmodule

// File: tb/tb_soc_top.sv
// Directed bench for soc_top: UART host driver, UART reply decoder, SPI flash model.
module tb_soc_top;

  localparam int BD = 16;
  localparam int SD = 2;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] parallel_i;
  logic [31:0] parallel_o;
  logic        flashClk_o, flashMosi_o, flashWp_o, flashHold_o, uartTx_o;
  logic        flashMiso_i = 1'b0;
  logic        uartRx_i;

  int checks = 0;
  int errors = 0;

  soc_top #(.BAUD_DIV(BD), .SPI_DIV(SD)) dut (
    .clk_i(clk), .rst_i(rst_i), .parallel_i(parallel_i), .parallel_o(parallel_o),
    .flashClk_o(flashClk_o), .flashMosi_o(flashMosi_o), .flashMiso_i(flashMiso_i),
    .flashWp_o(flashWp_o), .flashHold_o(flashHold_o), .uartTx_o(uartTx_o),
    .uartRx_i(uartRx_i)
  );

  always #5 clk = ~clk;

  // Reply decoder: bytes the DUT transmits land in rx_q.
  logic [7:0] rx_q[$];
  logic [7:0] mon_b;
  initial begin
    forever begin
      @(negedge clk);
      if (uartTx_o === 1'b0) begin
        repeat (BD / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BD) @(negedge clk);
          mon_b[i] = uartTx_o;
        end
        repeat (BD) @(negedge clk);
        rx_q.push_back(mon_b);
      end
    end
  end

  // SPI flash model (mode 0): captures 32 command bits, then returns 0xA5, 0x3C, zeros.
  int          rise_cnt = 0;
  int          last_rises = 0;
  logic [31:0] mosi_cap = '0;
  logic [15:0] stream = 16'hA53C;
  time         t_hold = 0;
  time         t_first = 0;

  always @(posedge flashClk_o or posedge flashHold_o) begin
    if (flashHold_o) begin
      if (rise_cnt != 0) last_rises = rise_cnt;
      rise_cnt = 0;
    end else begin
      if (rise_cnt == 0) t_first = $time;
      if (rise_cnt < 32) mosi_cap = {mosi_cap[30:0], flashMosi_o};
      rise_cnt++;
    end
  end

  always @(negedge flashClk_o) begin
    if (!flashHold_o) begin
      if (rise_cnt >= 32 && rise_cnt < 48) flashMiso_i = stream[15 - (rise_cnt - 32)];
      else                                 flashMiso_i = 1'b0;
    end
  end

  always @(negedge flashHold_o) t_hold = $time;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic uart_send(input logic [7:0] b, input logic stop_bit);
    uartRx_i = 1'b0;
    repeat (BD) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      uartRx_i = b[i];
      repeat (BD) @(posedge clk);
    end
    uartRx_i = stop_bit;
    repeat (BD) @(posedge clk);
    uartRx_i = 1'b1;
    if (!stop_bit) repeat (BD) @(posedge clk);
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] exp);
    int k;
    logic [7:0] got;
    k = 0;
    while (rx_q.size() == 0 && k < 40 * BD) begin
      @(posedge clk);
      k++;
    end
    if (rx_q.size() != 0) got = rx_q.pop_front();
    else                  got = 8'hxx;
    chk(tag, {24'h0, got}, {24'h0, exp});
  endtask

  task automatic gap();
    repeat (2 * BD) @(posedge clk);
  endtask

  initial begin
    rst_i      = 1'b1;
    uartRx_i   = 1'b1;
    parallel_i = 32'h0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_parallel_o", parallel_o, 32'h0);
    chk("rst_tx", {31'h0, uartTx_o}, 32'h1);
    chk("rst_hold", {31'h0, flashHold_o}, 32'h1);
    chk("rst_sck", {31'h0, flashClk_o}, 32'h0);
    chk("rst_wp", {31'h0, flashWp_o}, 32'h1);
    chk("rst_mosi", {31'h0, flashMosi_o}, 32'h0);
    @(negedge clk);
    rst_i = 1'b0;
    gap();

    // Write then read back the output register.
    uart_send(8'h57, 1'b1);
    uart_send(8'hDE, 1'b1);
    uart_send(8'hAD, 1'b1);
    uart_send(8'hBE, 1'b1);
    uart_send(8'hEF, 1'b1);
    expect_byte("w_ack", 8'h4B);
    chk("w_parallel_o", parallel_o, 32'hDEADBEEF);
    gap();
    uart_send(8'h4F, 1'b1);
    expect_byte("o_b0", 8'hDE);
    expect_byte("o_b1", 8'hAD);
    expect_byte("o_b2", 8'hBE);
    expect_byte("o_b3", 8'hEF);
    gap();

    // Sample input; a change during the reply must not leak in.
    parallel_i = 32'h12345678;
    uart_send(8'h52, 1'b1);
    parallel_i = 32'hFFFF0000;
    expect_byte("r_b0", 8'h12);
    expect_byte("r_b1", 8'h34);
    expect_byte("r_b2", 8'h56);
    expect_byte("r_b3", 8'h78);
    gap();

    // Two-byte flash read at 0x000100.
    uart_send(8'h46, 1'b1);
    uart_send(8'h00, 1'b1);
    uart_send(8'h01, 1'b1);
    uart_send(8'h00, 1'b1);
    uart_send(8'h02, 1'b1);
    expect_byte("f_d0", 8'hA5);
    expect_byte("f_d1", 8'h3C);
    gap();
    chk("f_mosi_cmd", mosi_cap, 32'h03000100);
    chk("f_sck_rises", last_rises, 32'd48);
    chk("f_hold_after", {31'h0, flashHold_o}, 32'h1);
    chk("f_sck_after", {31'h0, flashClk_o}, 32'h0);
    chk("f_mosi_after", {31'h0, flashMosi_o}, 32'h0);
    chk("f_hold_setup", {31'h0, ((t_first - t_hold) >= SD * 10)}, 32'h1);

    // Unknown command and a framing error.
    uart_send(8'h00, 1'b1);
    expect_byte("unk_reply", 8'h3F);
    gap();
    uart_send(8'h4F, 1'b0);
    repeat (20 * BD) @(posedge clk);
    chk("frame_err_silent", 32'(rx_q.size()), 32'h0);
    uart_send(8'h4F, 1'b1);
    expect_byte("post_fe_b0", 8'hDE);
    expect_byte("post_fe_b1", 8'hAD);
    expect_byte("post_fe_b2", 8'hBE);
    expect_byte("post_fe_b3", 8'hEF);
    gap();

    // Reset in the middle of a 256-byte flash stream.
    uart_send(8'h46, 1'b1);
    uart_send(8'h00, 1'b1);
    uart_send(8'h00, 1'b1);
    uart_send(8'h00, 1'b1);
    uart_send(8'h00, 1'b1);
    expect_byte("stream_d0", 8'hA5);
    @(negedge clk);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_hold", {31'h0, flashHold_o}, 32'h1);
    chk("abort_tx", {31'h0, uartTx_o}, 32'h1);
    @(negedge clk);
    rst_i = 1'b0;
    repeat (12 * BD) @(posedge clk);
    rx_q.delete();
    uart_send(8'h4F, 1'b1);
    expect_byte("post_rst_b0", 8'h00);
    expect_byte("post_rst_b1", 8'h00);
    expect_byte("post_rst_b2", 8'h00);
    expect_byte("post_rst_b3", 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
